// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ID/EX issue stage.
//   - default datapath / register-index widths
//   - ALU function codes (driven on ex_signal) and opcode constants
//   - immediate-select enum, EX control struct and the bubble control word
package alu_pkg;

    localparam int DW_DEF = 32;
    localparam int RW_DEF = 5;

    localparam logic [5:0] SIG_AND = 6'b100100;
    localparam logic [5:0] SIG_OR  = 6'b100101;
    localparam logic [5:0] SIG_ADD = 6'b100000;
    localparam logic [5:0] SIG_SUB = 6'b100010;
    localparam logic [5:0] SIG_SLT = 6'b101010;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,
        IMM_SEXT = 2'd1,
        IMM_ZEXT = 2'd2
    } imm_sel_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic illegal;
    } ex_ctrl_t;

    localparam ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational instruction decode for the issue stage.
// Ports:
//   i_op, i_funct      opcode / function fields
//   i_rt, i_rd         register fields (destination select)
//   o_signal           ALU function code
//   o_imm_sel          operand-B source: register, sign- or zero-extended immediate
//   o_ctrl             reg_write / mem_read / mem_write / branch / illegal
//   o_wr_reg           destination register (0 when nothing is written)
//   o_uses_rt          rt is a real source operand (R-type, sw, beq)
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    input  logic [4:0] i_rt,
    input  logic [4:0] i_rd,
    output logic [5:0] o_signal,
    output imm_sel_e   o_imm_sel,
    output ex_ctrl_t   o_ctrl,
    output logic [4:0] o_wr_reg,
    output logic       o_uses_rt
);

    always_comb begin
        o_signal  = SIG_ADD;
        o_imm_sel = IMM_NONE;
        o_ctrl    = CTRL_BUBBLE;
        o_wr_reg  = '0;
        o_uses_rt = 1'b0;
        case (i_op)
            OP_RTYPE: begin
                case (i_funct)
                    SIG_AND, SIG_OR, SIG_ADD, SIG_SUB, SIG_SLT: begin
                        o_signal         = i_funct;
                        o_wr_reg         = i_rd;
                        o_ctrl.reg_write = 1'b1;
                        o_uses_rt        = 1'b1;
                    end
                    default: o_ctrl.illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin
                o_imm_sel        = IMM_SEXT;
                o_wr_reg         = i_rt;
                o_ctrl.reg_write = 1'b1;
            end
            OP_ANDI: begin
                o_signal         = SIG_AND;
                o_imm_sel        = IMM_ZEXT;
                o_wr_reg         = i_rt;
                o_ctrl.reg_write = 1'b1;
            end
            OP_ORI: begin
                o_signal         = SIG_OR;
                o_imm_sel        = IMM_ZEXT;
                o_wr_reg         = i_rt;
                o_ctrl.reg_write = 1'b1;
            end
            OP_LW: begin
                o_imm_sel        = IMM_SEXT;
                o_wr_reg         = i_rt;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.mem_read  = 1'b1;
            end
            OP_SW: begin
                o_imm_sel        = IMM_SEXT;
                o_ctrl.mem_write = 1'b1;
                o_uses_rt        = 1'b1;
            end
            OP_BEQ: begin
                o_signal      = SIG_SUB;
                o_ctrl.branch = 1'b1;
                o_uses_rt     = 1'b1;
            end
            default: o_ctrl.illegal = 1'b1;
        endcase
        // Writes to register 0 are discarded, so they must not look like producers.
        if (o_wr_reg == 5'd0) o_ctrl.reg_write = 1'b0;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX pipeline register feeding the ALU, with RAW/load-use
// hazard detection and optional EX-stage operand forwarding.
// Build option: define ALU_ISSUE_FWD_EN to enable forwarding from MEM/WB.
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_id_valid/instr/rs_data/rt_data  instruction and register operands from ID
//   i_stall_in, i_flush               downstream hold, branch kill
//   i_mem_*, i_wb_*                   downstream destination / result info
//   o_hazard_stall                    combinational hold request to PC and IF/ID
//   o_ex_*                            registered EX slot (operands possibly forwarded)
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_id_valid,
    input  logic [31:0]   i_id_instr,
    input  logic [DW-1:0] i_id_rs_data,
    input  logic [DW-1:0] i_id_rt_data,
    input  logic          i_stall_in,
    input  logic          i_flush,
    input  logic [RW-1:0] i_mem_wr_reg,
    input  logic          i_mem_reg_write,
    input  logic [DW-1:0] i_mem_result,
    input  logic [RW-1:0] i_wb_wr_reg,
    input  logic          i_wb_reg_write,
    input  logic [DW-1:0] i_wb_result,
    output logic          o_hazard_stall,
    output logic          o_ex_valid,
    output logic [5:0]    o_ex_signal,
    output logic [DW-1:0] o_ex_dataA,
    output logic [DW-1:0] o_ex_dataB,
    output logic [DW-1:0] o_ex_store_data,
    output logic [RW-1:0] o_ex_wr_reg,
    output logic          o_ex_reg_write,
    output logic          o_ex_mem_read,
    output logic          o_ex_mem_write,
    output logic          o_ex_branch,
    output logic          o_ex_illegal
);

    logic [5:0]    w_dec_signal;
    imm_sel_e      w_dec_imm_sel;
    ex_ctrl_t      w_dec_ctrl;
    logic [4:0]    w_dec_wr_reg;
    logic          w_dec_uses_rt;

    logic [RW-1:0] w_rs;
    logic [RW-1:0] w_rt;
    logic [DW-1:0] w_id_b;
    logic          w_rs_hit;
    logic          w_rt_hit;
    logic          w_hazard;
    logic          w_load_id;

    logic          r_ex_valid;
    logic [5:0]    r_ex_signal;
    ex_ctrl_t      r_ex_ctrl;
    logic [DW-1:0] r_ex_dataA;
    logic [DW-1:0] r_ex_dataB;
    logic [DW-1:0] r_ex_store;
    logic [RW-1:0] r_ex_wr_reg;
    logic [RW-1:0] r_ex_rs;
    logic [RW-1:0] r_ex_rt;
    logic          r_ex_b_imm;

    alu_ctrl_decode u_decode (
        .i_op      (i_id_instr[31:26]),
        .i_funct   (i_id_instr[5:0]),
        .i_rt      (i_id_instr[20:16]),
        .i_rd      (i_id_instr[15:11]),
        .o_signal  (w_dec_signal),
        .o_imm_sel (w_dec_imm_sel),
        .o_ctrl    (w_dec_ctrl),
        .o_wr_reg  (w_dec_wr_reg),
        .o_uses_rt (w_dec_uses_rt)
    );

    assign w_rs = RW'(i_id_instr[25:21]);
    assign w_rt = RW'(i_id_instr[20:16]);

    always_comb begin
        case (w_dec_imm_sel)
            IMM_SEXT: w_id_b = {{(DW-16){i_id_instr[15]}}, i_id_instr[15:0]};
            IMM_ZEXT: w_id_b = {{(DW-16){1'b0}}, i_id_instr[15:0]};
            default:  w_id_b = i_id_rt_data;
        endcase
    end

`ifdef ALU_ISSUE_FWD_EN
    // Only a load in EX cannot be covered by forwarding.
    assign w_rs_hit = (w_rs != '0) && r_ex_valid && r_ex_ctrl.mem_read && (r_ex_wr_reg == w_rs);
    assign w_rt_hit = (w_rt != '0) && r_ex_valid && r_ex_ctrl.mem_read && (r_ex_wr_reg == w_rt);
`else
    // Without forwarding any producer in EX or MEM blocks; WB is covered by the
    // register file writing before it is read.
    assign w_rs_hit = (w_rs != '0) &&
                      ((r_ex_valid && r_ex_ctrl.reg_write && (r_ex_wr_reg == w_rs)) ||
                       (i_mem_reg_write && (i_mem_wr_reg == w_rs)));
    assign w_rt_hit = (w_rt != '0) &&
                      ((r_ex_valid && r_ex_ctrl.reg_write && (r_ex_wr_reg == w_rt)) ||
                       (i_mem_reg_write && (i_mem_wr_reg == w_rt)));
`endif

    assign w_hazard       = i_id_valid && !i_stall_in && !i_flush &&
                            (w_rs_hit || (w_dec_uses_rt && w_rt_hit));
    assign o_hazard_stall = w_hazard;
    assign w_load_id      = i_id_valid && !w_hazard && !i_flush;

    // Flush overrides the downstream hold; otherwise the slot only moves when not held.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ex_valid  <= 1'b0;
            r_ex_signal <= SIG_ADD;
            r_ex_ctrl   <= CTRL_BUBBLE;
            r_ex_dataA  <= '0;
            r_ex_dataB  <= '0;
            r_ex_store  <= '0;
            r_ex_wr_reg <= '0;
            r_ex_rs     <= '0;
            r_ex_rt     <= '0;
            r_ex_b_imm  <= 1'b0;
        end else if (i_flush || !i_stall_in) begin
            if (w_load_id) begin
                r_ex_valid  <= 1'b1;
                r_ex_signal <= w_dec_signal;
                r_ex_ctrl   <= w_dec_ctrl;
                r_ex_dataA  <= i_id_rs_data;
                r_ex_dataB  <= w_id_b;
                r_ex_store  <= i_id_rt_data;
                r_ex_wr_reg <= RW'(w_dec_wr_reg);
                r_ex_rs     <= w_rs;
                r_ex_rt     <= w_dec_uses_rt ? w_rt : '0;
                r_ex_b_imm  <= (w_dec_imm_sel != IMM_NONE);
            end else begin
                r_ex_valid  <= 1'b0;
                r_ex_signal <= SIG_ADD;
                r_ex_ctrl   <= CTRL_BUBBLE;
                r_ex_dataA  <= '0;
                r_ex_dataB  <= '0;
                r_ex_store  <= '0;
                r_ex_wr_reg <= '0;
                r_ex_rs     <= '0;
                r_ex_rt     <= '0;
                r_ex_b_imm  <= 1'b0;
            end
        end
    end

`ifdef ALU_ISSUE_FWD_EN
    // Source index 0 never matches, so bubbles and unused rt fall through.
    function automatic logic [DW-1:0] fwd_sel(input logic [RW-1:0] src, input logic [DW-1:0] reg_val);
        if (src != '0 && i_mem_reg_write && i_mem_wr_reg == src)
            return i_mem_result;
        else if (src != '0 && i_wb_reg_write && i_wb_wr_reg == src)
            return i_wb_result;
        else
            return reg_val;
    endfunction

    assign o_ex_dataA      = fwd_sel(r_ex_rs, r_ex_dataA);
    assign o_ex_dataB      = r_ex_b_imm ? r_ex_dataB : fwd_sel(r_ex_rt, r_ex_dataB);
    assign o_ex_store_data = fwd_sel(r_ex_rt, r_ex_store);
`else
    logic w_unused;
    assign w_unused = ^{i_mem_result, i_wb_wr_reg, i_wb_reg_write, i_wb_result,
                        r_ex_rs, r_ex_rt, r_ex_b_imm};

    assign o_ex_dataA      = r_ex_dataA;
    assign o_ex_dataB      = r_ex_dataB;
    assign o_ex_store_data = r_ex_store;
`endif

    assign o_ex_valid     = r_ex_valid;
    assign o_ex_signal    = r_ex_signal;
    assign o_ex_wr_reg    = r_ex_wr_reg;
    assign o_ex_reg_write = r_ex_ctrl.reg_write;
    assign o_ex_mem_read  = r_ex_ctrl.mem_read;
    assign o_ex_mem_write = r_ex_ctrl.mem_write;
    assign o_ex_branch    = r_ex_ctrl.branch;
    assign o_ex_illegal   = r_ex_ctrl.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic        clk_sys;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic        stall_in;
    logic        flush;
    logic [4:0]  mem_wr_reg;
    logic        mem_reg_write;
    logic [31:0] mem_result;
    logic [4:0]  wb_wr_reg;
    logic        wb_reg_write;
    logic [31:0] wb_result;
    logic        hazard_stall;
    logic        ex_valid;
    logic [5:0]  ex_signal;
    logic [31:0] ex_data_a;
    logic [31:0] ex_data_b;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_wr_reg;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_branch;
    logic        ex_illegal;

    int n_cmp = 0;
    int n_err = 0;

    alu_issue_stage #(.DW(32), .RW(5)) dut (
        .i_clk           (clk_sys),
        .i_rst           (rst),
        .i_id_valid      (id_valid),
        .i_id_instr      (id_instr),
        .i_id_rs_data    (id_rs_data),
        .i_id_rt_data    (id_rt_data),
        .i_stall_in      (stall_in),
        .i_flush         (flush),
        .i_mem_wr_reg    (mem_wr_reg),
        .i_mem_reg_write (mem_reg_write),
        .i_mem_result    (mem_result),
        .i_wb_wr_reg     (wb_wr_reg),
        .i_wb_reg_write  (wb_reg_write),
        .i_wb_result     (wb_result),
        .o_hazard_stall  (hazard_stall),
        .o_ex_valid      (ex_valid),
        .o_ex_signal     (ex_signal),
        .o_ex_dataA      (ex_data_a),
        .o_ex_dataB      (ex_data_b),
        .o_ex_store_data (ex_store_data),
        .o_ex_wr_reg     (ex_wr_reg),
        .o_ex_reg_write  (ex_reg_write),
        .o_ex_mem_read   (ex_mem_read),
        .o_ex_mem_write  (ex_mem_write),
        .o_ex_branch     (ex_branch),
        .o_ex_illegal    (ex_illegal)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] rs_d, input logic [31:0] rt_d);
        id_valid   = 1'b1;
        id_instr   = instr;
        id_rs_data = rs_d;
        id_rt_data = rt_d;
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    initial begin
        rst = 1'b1; id_valid = 1'b0; id_instr = '0; id_rs_data = '0; id_rt_data = '0;
        stall_in = 1'b0; flush = 1'b0;
        mem_wr_reg = '0; mem_reg_write = 1'b0; mem_result = '0;
        wb_wr_reg = '0; wb_reg_write = 1'b0; wb_result = '0;
        step(); step();
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_signal", 32'(ex_signal), 32'h20);
        chk("rst_dataA", ex_data_a, 32'd0);
        chk("rst_wr_reg", 32'(ex_wr_reg), 32'd0);
        chk("rst_hazard", 32'(hazard_stall), 32'd0);
        rst = 1'b0;

        // add r3, r1(5), r2(7)
        drive(rtype(1, 2, 3, 6'h20), 32'd5, 32'd7);
        step();
        chk("add_signal", 32'(ex_signal), 32'h20);
        chk("add_A", ex_data_a, 32'd5);
        chk("add_B", ex_data_b, 32'd7);
        chk("add_wr", 32'(ex_wr_reg), 32'd3);
        chk("add_rw", 32'(ex_reg_write), 32'd1);
        chk("add_valid", 32'(ex_valid), 32'd1);

        drive(itype(OP_ADDI, 0, 4, 16'hFFFF), 32'd0, 32'h99);
        step();
        chk("addi_B_sext", ex_data_b, 32'hFFFF_FFFF);
        chk("addi_wr", 32'(ex_wr_reg), 32'd4);

        drive(itype(OP_ANDI, 0, 4, 16'hFFFF), 32'd0, 32'h99);
        step();
        chk("andi_B_zext", ex_data_b, 32'h0000_FFFF);
        chk("andi_signal", 32'(ex_signal), 32'h24);

        drive(itype(OP_ORI, 0, 6, 16'h1234), 32'd0, 32'd0);
        step();
        chk("ori_signal", 32'(ex_signal), 32'h25);
        chk("ori_B", ex_data_b, 32'h1234);

        drive(itype(OP_LW, 0, 8, 16'h0004), 32'd0, 32'd0);
        step();
        chk("lw_mem_read", 32'(ex_mem_read), 32'd1);
        chk("lw_wr", 32'(ex_wr_reg), 32'd8);
        chk("lw_rw", 32'(ex_reg_write), 32'd1);

        // add r9, r8, r1 right behind the load
        drive(rtype(8, 1, 9, 6'h20), 32'h55, 32'h66);
        #1 chk("lu_hazard_on", 32'(hazard_stall), 32'd1);
        step();
        chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
        chk("lu_bubble_mr", 32'(ex_mem_read), 32'd0);
        chk("lu_hazard_off", 32'(hazard_stall), 32'd0);
        step();
        chk("lu_add_valid", 32'(ex_valid), 32'd1);
        chk("lu_add_wr", 32'(ex_wr_reg), 32'd9);
        chk("lu_add_A", ex_data_a, 32'h55);

        drive(itype(OP_SW, 2, 3, 16'h0008), 32'd100, 32'hAB);
        step();
        chk("sw_A", ex_data_a, 32'd100);
        chk("sw_B", ex_data_b, 32'd8);
        chk("sw_store", ex_store_data, 32'hAB);
        chk("sw_mw", 32'(ex_mem_write), 32'd1);
        chk("sw_rw", 32'(ex_reg_write), 32'd0);

        drive(itype(OP_BEQ, 1, 2, 16'h0010), 32'd1, 32'd2);
        step();
        chk("beq_signal", 32'(ex_signal), 32'h22);
        chk("beq_B", ex_data_b, 32'd2);
        chk("beq_branch", 32'(ex_branch), 32'd1);

        drive(rtype(1, 2, 3, 6'b000111), 32'd1, 32'd2);
        step();
        chk("ill_funct", 32'(ex_illegal), 32'd1);
        chk("ill_valid", 32'(ex_valid), 32'd1);
        chk("ill_rw", 32'(ex_reg_write), 32'd0);
        chk("ill_signal", 32'(ex_signal), 32'h20);

        drive(rtype(1, 2, 0, 6'h24), 32'd1, 32'd2);
        step();
        chk("rd0_rw", 32'(ex_reg_write), 32'd0);
        chk("rd0_signal", 32'(ex_signal), 32'h24);
        chk("rd0_illegal", 32'(ex_illegal), 32'd0);

        drive(itype(6'b111111, 1, 2, 16'h0), 32'd0, 32'd0);
        step();
        chk("ill_op", 32'(ex_illegal), 32'd1);

        // MEM-stage producer; r0 never matches
        mem_wr_reg = 5'd0; mem_reg_write = 1'b1;
        drive(rtype(0, 0, 7, 6'h20), 32'd0, 32'd0);
        #1 chk("r0_no_hazard", 32'(hazard_stall), 32'd0);
        mem_wr_reg = 5'd5;
        drive(rtype(5, 0, 7, 6'h20), 32'd0, 32'd0);
`ifdef ALU_ISSUE_FWD_EN
        #1 chk("mem_hazard", 32'(hazard_stall), 32'd0);
`else
        #1 chk("mem_hazard", 32'(hazard_stall), 32'd1);
`endif
        mem_wr_reg = 5'd0; mem_reg_write = 1'b0;
        drive(rtype(3, 1, 5, 6'h20), 32'd0, 32'd0);
        step();
        // EX now holds a writer of r5; same consumer again while flushing
        drive(rtype(5, 1, 6, 6'h20), 32'd0, 32'd0);
`ifdef ALU_ISSUE_FWD_EN
        #1 chk("ex_hazard", 32'(hazard_stall), 32'd0);
`else
        #1 chk("ex_hazard", 32'(hazard_stall), 32'd1);
`endif
        stall_in = 1'b1;
        #1 chk("stall_masks_haz", 32'(hazard_stall), 32'd0);
        stall_in = 1'b0; flush = 1'b1;
        #1 chk("flush_masks_haz", 32'(hazard_stall), 32'd0);
        step();
        chk("flush_bubble", 32'(ex_valid), 32'd0);
        flush = 1'b0;

        id_valid = 1'b0;
        step();
        chk("idle_bubble", 32'(ex_valid), 32'd0);

        // stall three cycles, flush on the second
        drive(rtype(1, 2, 3, 6'h22), 32'd9, 32'd4);
        step();
        chk("pre_stall_signal", 32'(ex_signal), 32'h22);
        stall_in = 1'b1;
        drive(rtype(1, 2, 4, 6'h20), 32'd1, 32'd1);
        step();
        chk("hold_signal", 32'(ex_signal), 32'h22);
        chk("hold_A", ex_data_a, 32'd9);
        chk("hold_wr", 32'(ex_wr_reg), 32'd3);
        flush = 1'b1;
        step();
        chk("stall_flush_valid", 32'(ex_valid), 32'd0);
        chk("stall_flush_A", ex_data_a, 32'd0);
        flush = 1'b0;
        step();
        chk("stall_after_flush", 32'(ex_valid), 32'd0);

        stall_in = 1'b0;
        drive(rtype(1, 2, 7, 6'h2A), 32'd3, 32'd4);
        step();
        chk("slt_signal", 32'(ex_signal), 32'h2A);
        stall_in = 1'b1; rst = 1'b1;
        step();
        chk("rst_stall_valid", 32'(ex_valid), 32'd0);
        chk("rst_stall_signal", 32'(ex_signal), 32'h20);
        chk("rst_stall_wr", 32'(ex_wr_reg), 32'd0);
        rst = 1'b0; stall_in = 1'b0;

`ifdef ALU_ISSUE_FWD_EN
        drive(rtype(5, 6, 7, 6'h20), 32'd1, 32'd2);
        step();
        id_valid = 1'b0;
        mem_wr_reg = 5'd5; mem_reg_write = 1'b1; mem_result = 32'h11;
        wb_wr_reg = 5'd5; wb_reg_write = 1'b1; wb_result = 32'h22;
        #1 chk("fwd_mem_prio", ex_data_a, 32'h11);
        mem_reg_write = 1'b0;
        #1 chk("fwd_wb", ex_data_a, 32'h22);
        wb_wr_reg = 5'd6;
        #1 chk("fwd_wb_B", ex_data_b, 32'h22);
        wb_reg_write = 1'b0;
        #1 chk("fwd_none", ex_data_b, 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
